// File: rtl/slave_daq_multi_ctrl.sv
// Slave-mode DAQ controller for NUM_ASIC daisy-chained MICROROC ASICs: trigger-driven acquisition/readout
// with power pulsing and a run trailer. Define SLAVE_DAQ_TIMEOUT_EN to enable the readout watchdog.
module slave_daq_multi_ctrl #(
    parameter int          NUM_ASIC      = 4,
    parameter int          TRIG_CNT_W    = 32,
    parameter int          T_PWR_RESET   = 8,
    parameter int          T_RESET_START = 40,
    parameter int          T_SRO         = 16,
    parameter logic [15:0] TAIL_WORD     = 16'hFF45,
    parameter int          READ_TIMEOUT  = 65535
) (
    input  logic                Clk,
    input  logic                reset_n,
    input  logic                ModuleStart,
    input  logic                AcqStart,
    input  logic                EndReadout,
    input  logic [NUM_ASIC-1:0] ChipSatB,
    input  logic [15:0]         AcquisitionTime,
    input  logic [15:0]         EndHoldTime,
    output logic                RESET_B,
    output logic                START_ACQ,
    output logic                ForceExternalRaz,
    output logic                StartReadout,
    output logic                PWR_ON_A,
    output logic                PWR_ON_D,
    output logic                PWR_ON_DAC,
    output logic                PWR_ON_ADC,
    output logic                OnceEnd,
    output logic                AllDone,
    output logic                TimeoutFlag,
    input  logic [15:0]         MicrorocData,
    input  logic                MicrorocData_en,
    output logic [15:0]         SlaveDaqData,
    output logic                SlaveDaqData_en,
    input  logic                DataTransmitDone
);

    typedef enum logic [3:0] {
        IDLE, CHIP_RESET, POWER_ON, RELEASE, WAIT_START, ACQUIRE, WAIT_READ,
        START_READOUT, WAIT_READ_DONE, ONCE_END, OUT_TAIL, OUT_COUNT, ALL_DONE
    } state_t;

    localparam int          NW        = TRIG_CNT_W / 16;
    localparam logic [1:0]  NW_C      = 2'(NW);
    localparam logic [31:0] T_PWR_C   = 32'(T_PWR_RESET);
    localparam logic [31:0] T_RST_C   = 32'(T_RESET_START);
    localparam logic [31:0] T_SRO_C   = 32'(T_SRO);

    state_t                  state_q, state_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [1:0]              wi_q, wi_d;
    logic [TRIG_CNT_W-1:0]   trig_cnt_q, trig_cnt_d;
    logic [15:0]             acq_cnt_q, acq_cnt_d;
    logic [15:0]             dout_q, dout_d;
    logic                    dout_en_q, dout_en_d;

    logic                    acq_s1_q, acq_s2_q, acq_s3_q;
    logic                    er_s1_q, er_s2_q;
    logic [NUM_ASIC-1:0]     sat_s1_q, sat_s2_q;
    logic                    sat_prev_q;

    logic                    trig, sat_all, full, read_ok, cnt_en;
    logic [TRIG_CNT_W-1:0]   trig_sh;

`ifdef SLAVE_DAQ_TIMEOUT_EN
    localparam logic [31:0]  RD_TO_C = 32'(READ_TIMEOUT);
    logic [31:0]             wd_q, wd_d;
    logic                    timeout_q, timeout_d;
`endif

    assign sat_all = &sat_s2_q;
    assign trig    = acq_s2_q & ~acq_s3_q;
    assign full    = ~sat_all & sat_prev_q;
    assign read_ok = sat_all & ~sat_prev_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 32'd1;
        wi_d       = wi_q;
        trig_cnt_d = trig_cnt_q;
        acq_cnt_d  = acq_cnt_q;
        dout_d     = MicrorocData;
        dout_en_d  = MicrorocData_en;
        trig_sh    = '0;
`ifdef SLAVE_DAQ_TIMEOUT_EN
        wd_d       = wd_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                trig_cnt_d = '0;
                acq_cnt_d  = '0;
                if (ModuleStart) state_d = CHIP_RESET;
            end
            CHIP_RESET:     state_d = POWER_ON;
            POWER_ON:       if (cnt_q >= T_PWR_C) state_d = RELEASE;
            RELEASE:        if (cnt_q >= T_RST_C) state_d = WAIT_START;
            // A falling ModuleStart wins over a trigger seen in the same cycle
            WAIT_START: begin
                if (!ModuleStart) state_d = OUT_TAIL;
                else if (trig)    state_d = ACQUIRE;
            end
            ACQUIRE:        if (cnt_q >= {16'd0, AcquisitionTime} || full) state_d = WAIT_READ;
            WAIT_READ:      if (read_ok) state_d = START_READOUT;
            START_READOUT:  if (cnt_q >= T_SRO_C) state_d = WAIT_READ_DONE;
            WAIT_READ_DONE: begin
                if (er_s2_q) begin
                    state_d   = ONCE_END;
                    acq_cnt_d = (acq_cnt_q == 16'hFFFF) ? acq_cnt_q : acq_cnt_q + 16'd1;
                end
            end
            ONCE_END:       if (cnt_q >= {16'd0, EndHoldTime}) state_d = WAIT_START;
            OUT_TAIL: begin
                state_d   = OUT_COUNT;
                wi_d      = '0;
                dout_d    = TAIL_WORD;
                dout_en_d = 1'b1;
            end
            // Trigger count MSW first, then the completed-readout count
            OUT_COUNT: begin
                wi_d      = wi_q + 2'd1;
                dout_en_d = 1'b1;
                if (wi_q == NW_C) begin
                    dout_d  = acq_cnt_q;
                    state_d = ALL_DONE;
                end else begin
                    trig_sh = trig_cnt_q >> (16 * (NW - 1 - int'(wi_q)));
                    dout_d  = trig_sh[15:0];
                end
            end
            ALL_DONE:       if (DataTransmitDone) state_d = IDLE;
            default:        state_d = IDLE;
        endcase

`ifdef SLAVE_DAQ_TIMEOUT_EN
        if (state_q == IDLE) timeout_d = 1'b0;
        if (state_q == ACQUIRE) begin
            wd_d = '0;
        end else if (state_q == WAIT_READ || state_q == WAIT_READ_DONE) begin
            wd_d = wd_q + 32'd1;
            if (state_d == state_q && wd_q + 32'd1 >= RD_TO_C) begin
                state_d   = ONCE_END;
                timeout_d = 1'b1;
            end
        end
`endif

        if (state_d != state_q) cnt_d = '0;

        cnt_en = (state_q >= WAIT_START) && (state_q <= ONCE_END) &&
                 !(state_q == WAIT_START && !ModuleStart);
        if (trig && cnt_en) trig_cnt_d = trig_cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wi_q       <= '0;
            trig_cnt_q <= '0;
            acq_cnt_q  <= '0;
            dout_q     <= '0;
            dout_en_q  <= 1'b0;
            acq_s1_q   <= 1'b0;
            acq_s2_q   <= 1'b0;
            acq_s3_q   <= 1'b0;
            er_s1_q    <= 1'b0;
            er_s2_q    <= 1'b0;
            sat_s1_q   <= '1;
            sat_s2_q   <= '1;
            sat_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wi_q       <= wi_d;
            trig_cnt_q <= trig_cnt_d;
            acq_cnt_q  <= acq_cnt_d;
            dout_q     <= dout_d;
            dout_en_q  <= dout_en_d;
            acq_s1_q   <= AcqStart;
            acq_s2_q   <= acq_s1_q;
            acq_s3_q   <= acq_s2_q;
            er_s1_q    <= EndReadout;
            er_s2_q    <= er_s1_q;
            sat_s1_q   <= ChipSatB;
            sat_s2_q   <= sat_s1_q;
            sat_prev_q <= sat_all;
        end
    end

`ifdef SLAVE_DAQ_TIMEOUT_EN
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
    assign TimeoutFlag = timeout_q;
`else
    assign TimeoutFlag = 1'b0;
`endif

    assign RESET_B          = !(state_q == CHIP_RESET || state_q == POWER_ON);
    assign START_ACQ        = (state_q == ACQUIRE);
    assign ForceExternalRaz = ~START_ACQ;
    assign StartReadout     = (state_q == START_READOUT);
    assign PWR_ON_A         = (state_q >= CHIP_RESET) && (state_q <= ONCE_END);
    assign PWR_ON_DAC       = PWR_ON_A;
    assign PWR_ON_D         = (state_q >= POWER_ON) && (state_q <= ONCE_END);
    assign PWR_ON_ADC       = 1'b0;
    assign OnceEnd          = (state_q == ONCE_END);
    assign AllDone          = (state_q == ALL_DONE);
    assign SlaveDaqData     = dout_q;
    assign SlaveDaqData_en  = dout_en_q;

endmodule

// File: tb/tb_slave_daq_multi_ctrl.sv
// Directed bench for slave_daq_multi_ctrl: run sequencing, trailer contents, Full/ReadOk handling, reset.
module tb_slave_daq_multi_ctrl;

    logic        Clk = 1'b0;
    logic        reset_n, ModuleStart, AcqStart, EndReadout, DataTransmitDone;
    logic [3:0]  ChipSatB;
    logic [15:0] AcquisitionTime, EndHoldTime, MicrorocData;
    logic        MicrorocData_en;
    logic        RESET_B, START_ACQ, ForceExternalRaz, StartReadout;
    logic        PWR_ON_A, PWR_ON_D, PWR_ON_DAC, PWR_ON_ADC;
    logic        OnceEnd, AllDone, TimeoutFlag, SlaveDaqData_en;
    logic [15:0] SlaveDaqData;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    slave_daq_multi_ctrl #(.READ_TIMEOUT(100)) dut (
        .Clk(Clk), .reset_n(reset_n), .ModuleStart(ModuleStart), .AcqStart(AcqStart),
        .EndReadout(EndReadout), .ChipSatB(ChipSatB), .AcquisitionTime(AcquisitionTime),
        .EndHoldTime(EndHoldTime), .RESET_B(RESET_B), .START_ACQ(START_ACQ),
        .ForceExternalRaz(ForceExternalRaz), .StartReadout(StartReadout),
        .PWR_ON_A(PWR_ON_A), .PWR_ON_D(PWR_ON_D), .PWR_ON_DAC(PWR_ON_DAC),
        .PWR_ON_ADC(PWR_ON_ADC), .OnceEnd(OnceEnd), .AllDone(AllDone),
        .TimeoutFlag(TimeoutFlag), .MicrorocData(MicrorocData),
        .MicrorocData_en(MicrorocData_en), .SlaveDaqData(SlaveDaqData),
        .SlaveDaqData_en(SlaveDaqData_en), .DataTransmitDone(DataTransmitDone)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic get_sig(input int id);
        case (id)
            0:       return START_ACQ;
            1:       return StartReadout;
            2:       return OnceEnd;
            3:       return AllDone;
            4:       return SlaveDaqData_en;
            default: return RESET_B;
        endcase
    endfunction

    // Cycles (negedges) until signal id reaches val; an expired budget shows up as a failed check
    task automatic wait_for(input string tag, input int id, input logic val, input int budget, output int n);
        n = 0;
        while (get_sig(id) !== val && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check_eq({tag, " reached"}, 32'(get_sig(id)), 32'(val));
    endtask

    task automatic width_of(input int id, input logic lvl, output int n);
        n = 0;
        while (get_sig(id) === lvl && n < 300) begin
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic start_run();
        int n;
        ModuleStart = 1'b1;
        wait_for("reset_b low", 5, 1'b0, 5, n);
        width_of(5, 1'b0, n);
        check_eq("reset_b low width", 32'(n), 32'd10);
        repeat (45) @(negedge Clk);
        check_eq("pwr_on a/d/dac/adc", 32'({PWR_ON_A, PWR_ON_D, PWR_ON_DAC, PWR_ON_ADC}), 32'b1110);
    endtask

    task automatic trigger(input int acq_width);
        int n;
        AcqStart = 1'b1;
        wait_for("start_acq", 0, 1'b1, 10, n);
        check_eq("trig latency", 32'(n), 32'd3);
        AcqStart = 1'b0;
        if (acq_width > 0) begin
            width_of(0, 1'b1, n);
            check_eq("start_acq width", 32'(n), 32'(acq_width));
        end
    endtask

    task automatic readout_start(input int lat);
        int n;
        wait_for("start_readout", 1, 1'b1, 10, n);
        check_eq("readok latency", 32'(n), 32'(lat));
        width_of(1, 1'b1, n);
        check_eq("start_readout width", 32'(n), 32'd17);
    endtask

    task automatic readout_end();
        int n;
        EndReadout = 1'b1;
        wait_for("once_end", 2, 1'b1, 10, n);
        check_eq("endreadout latency", 32'(n), 32'd3);
        EndReadout = 1'b0;
        width_of(2, 1'b1, n);
        check_eq("once_end width", 32'(n), 32'd5);
    endtask

    task automatic run_cycle();
        trigger(9);
        ChipSatB = 4'b1110;
        repeat (3) @(negedge Clk);
        ChipSatB = 4'hF;
        readout_start(3);
        readout_end();
    endtask

    task automatic read_trailer(input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
        int n;
        wait_for("trailer", 4, 1'b1, 10, n);
        check_eq("tail word", 32'(SlaveDaqData), 32'hFF45);
        @(negedge Clk);
        check_eq("trig msw", 32'({SlaveDaqData_en, SlaveDaqData}), {15'd0, 1'b1, w1});
        @(negedge Clk);
        check_eq("trig lsw", 32'({SlaveDaqData_en, SlaveDaqData}), {15'd0, 1'b1, w2});
        @(negedge Clk);
        check_eq("acq count", 32'({SlaveDaqData_en, SlaveDaqData}), {15'd0, 1'b1, w3});
        @(negedge Clk);
        check_eq("trailer end en", 32'(SlaveDaqData_en), 32'd0);
        check_eq("all_done set", 32'(AllDone), 32'd1);
        repeat (3) @(negedge Clk);
        check_eq("all_done held", 32'(AllDone), 32'd1);
        DataTransmitDone = 1'b1;
        @(negedge Clk);
        DataTransmitDone = 1'b0;
        check_eq("all_done cleared", 32'(AllDone), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global time limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0; ModuleStart = 1'b0; AcqStart = 1'b0; EndReadout = 1'b0;
        DataTransmitDone = 1'b0; ChipSatB = 4'hF; AcquisitionTime = 16'd8; EndHoldTime = 16'd4;
        MicrorocData = 16'h0; MicrorocData_en = 1'b0;
        repeat (3) @(negedge Clk);
        check_eq("reset outputs", 32'({RESET_B, START_ACQ, ForceExternalRaz, StartReadout, PWR_ON_A,
                 PWR_ON_D, PWR_ON_DAC, PWR_ON_ADC, OnceEnd, AllDone, TimeoutFlag, SlaveDaqData_en}),
                 32'b1010_0000_0000);
        check_eq("reset data", 32'(SlaveDaqData), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Three normal acquisitions, then the trailer
        start_run();
        MicrorocData = 16'hA5C3; MicrorocData_en = 1'b1;
        @(negedge Clk);
        check_eq("passthrough", 32'({SlaveDaqData_en, SlaveDaqData}), 32'h1A5C3);
        MicrorocData = 16'h0; MicrorocData_en = 1'b0;
        @(negedge Clk);
        repeat (3) run_cycle();
        ModuleStart = 1'b0;
        check_eq("timeout flag idle", 32'(TimeoutFlag), 32'd0);
        read_trailer(16'h0000, 16'h0003, 16'h0003);

        // Full during acquisition cuts the window; readout waits for every ASIC to release
        start_run();
        AcquisitionTime = 16'd100;
        trigger(0);
        repeat (2) @(negedge Clk);
        ChipSatB = 4'b1011;
        wait_for("full stop", 0, 1'b0, 10, n);
        check_eq("full latency", 32'(n), 32'd3);
        repeat (10) @(negedge Clk);
        check_eq("readout held", 32'(StartReadout), 32'd0);
        ChipSatB = 4'hF;
        readout_start(3);
        readout_end();

        // Trigger coinciding with ModuleStart falling is ignored
        AcqStart = 1'b1;
        repeat (2) @(negedge Clk);
        ModuleStart = 1'b0;
        @(negedge Clk);
        check_eq("no acq on stop", 32'(START_ACQ), 32'd0);
        AcqStart = 1'b0;
        read_trailer(16'h0000, 16'h0001, 16'h0001);

`ifdef SLAVE_DAQ_TIMEOUT_EN
        start_run();
        AcquisitionTime = 16'd8;
        trigger(9);
        ChipSatB = 4'b1110;
        repeat (3) @(negedge Clk);
        ChipSatB = 4'hF;
        readout_start(3);
        wait_for("timeout once_end", 2, 1'b1, 150, n);
        check_eq("timeout flag", 32'(TimeoutFlag), 32'd1);
        width_of(2, 1'b1, n);
        ModuleStart = 1'b0;
        read_trailer(16'h0000, 16'h0001, 16'h0000);
`endif

        // Asynchronous reset in the middle of START_READOUT
        AcquisitionTime = 16'd8;
        start_run();
        trigger(9);
        ChipSatB = 4'b1110;
        repeat (3) @(negedge Clk);
        ChipSatB = 4'hF;
        wait_for("sro before reset", 1, 1'b1, 10, n);
        repeat (3) @(negedge Clk);
        ModuleStart = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("reset sro", 32'({StartReadout, RESET_B, ForceExternalRaz, PWR_ON_A}), 32'b0110);
        @(negedge Clk);
        reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        check_eq("idle after reset", 32'({PWR_ON_A, PWR_ON_D, RESET_B, AllDone}), 32'b0010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
